// File: rtl/hmem_mctl.sv
// Memory-side line controller: splits one cache-line read or write from the
// arbiter into 64-bit request/acknowledge beats and reassembles read beats.
module hmem_mctl #(
   parameter int HLINE = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [63:0]      h_addr,
   input  logic             h_rd,
   input  logic             h_wr,
   input  logic [HLINE-1:0] h_data_out,
   output logic [HLINE-1:0] h_data_in,
   output logic             h_dv,
   output logic [63:0]      m_addr,
   output logic [63:0]      m_wdata,
   output logic             m_we,
   output logic             m_req,
   input  logic             m_ack,
   input  logic [63:0]      m_rdata
);

   localparam int BEATS = HLINE / 64;
   localparam int OFFS  = $clog2(HLINE / 8);
   localparam int CW    = $clog2(BEATS);
   localparam logic [63:0]   OFF_MASK = (64'd1 << OFFS) - 64'd1;
   localparam logic [CW-1:0] LAST     = CW'(BEATS - 1);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RSP, S_HOLD} state_t;

   state_t           state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [63:0]      base, base_n, line_base;
   logic [HLINE-1:0] wbuf, wbuf_n, rbuf, rbuf_n, h_data_in_n;
   logic [63:0]      m_addr_n, m_wdata_n;
   logic             m_we_n, m_req_n, h_dv_n;

   assign line_base = h_addr & ~OFF_MASK;

   // NOTE: registers use non-blocking assignments so every flop samples the
   // pre-edge value of every other flop, independent of statement order.
   // NOTE: the line buffers are reset as well, because rbuf reaches h_data_in
   // and a reset must leave no stale beats visible to the arbiter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         base      <= '0;
         wbuf      <= '0;
         rbuf      <= '0;
         h_data_in <= '0;
         h_dv      <= 1'b0;
         m_addr    <= '0;
         m_wdata   <= '0;
         m_we      <= 1'b0;
         m_req     <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         base      <= base_n;
         wbuf      <= wbuf_n;
         rbuf      <= rbuf_n;
         h_data_in <= h_data_in_n;
         h_dv      <= h_dv_n;
         m_addr    <= m_addr_n;
         m_wdata   <= m_wdata_n;
         m_we      <= m_we_n;
         m_req     <= m_req_n;
      end
   end

   // Memory-port outputs are computed one cycle ahead so they leave the block
   // straight from flops and stay stable while a beat waits for m_ack.
   // NOTE: every variable gets a default first so no path through the case
   // leaves one unassigned, which would infer a latch.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      base_n      = base;
      wbuf_n      = wbuf;
      rbuf_n      = rbuf;
      h_data_in_n = h_data_in;
      h_dv_n      = 1'b0;
      m_addr_n    = m_addr;
      m_wdata_n   = m_wdata;
      m_we_n      = m_we;
      m_req_n     = 1'b0;

      case (state)
         S_IDLE: begin
            if (h_wr) begin
               wbuf_n    = h_data_out;
               base_n    = line_base;
               cnt_n     = '0;
               state_n   = S_WR;
               m_req_n   = 1'b1;
               m_we_n    = 1'b1;
               m_addr_n  = line_base;
               m_wdata_n = h_data_out[63:0];
            end else if (h_rd) begin
               base_n   = line_base;
               cnt_n    = '0;
               state_n  = S_RD;
               m_req_n  = 1'b1;
               m_we_n   = 1'b0;
               m_addr_n = line_base;
            end
         end

         S_WR, S_RD: begin
            m_req_n = 1'b1;
            if (m_ack) begin
               if (state == S_RD)
                  rbuf_n[64*int'(cnt) +: 64] = m_rdata;
               if (cnt == LAST) begin
                  state_n = S_RSP;
                  m_req_n = 1'b0;
                  h_dv_n  = 1'b1;
                  if (state == S_RD)
                     h_data_in_n = rbuf_n;
               end else begin
                  cnt_n     = cnt + 1'b1;
                  m_addr_n  = base + (64'(cnt_n) << 3);
                  m_wdata_n = wbuf[64*int'(cnt_n) +: 64];
               end
            end
         end

         S_RSP:   state_n = S_HOLD;
         // Arbiter drops its request after h_dv; it is not looked at here.
         S_HOLD:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_hmem_mctl.sv
// Directed bench for hmem_mctl: a line-level model predicts every beat and
// every completion; the bench also plays the role of the beat memory.
module tb_hmem_mctl;

   localparam int HLINE = 256;
   localparam int BEATS = HLINE / 64;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [63:0]      h_addr = '0;
   logic             h_rd = 1'b0;
   logic             h_wr = 1'b0;
   logic [HLINE-1:0] h_data_out = '0;
   logic [HLINE-1:0] h_data_in;
   logic             h_dv;
   logic [63:0]      m_addr, m_wdata;
   logic             m_we, m_req;
   logic             m_ack = 1'b0;
   logic [63:0]      m_rdata = '0;

   hmem_mctl #(.HLINE(HLINE)) dut (
      .clk(clk), .rst(rst), .h_addr(h_addr), .h_rd(h_rd), .h_wr(h_wr),
      .h_data_out(h_data_out), .h_data_in(h_data_in), .h_dv(h_dv),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_req(m_req),
      .m_ack(m_ack), .m_rdata(m_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic             we;
      logic [63:0]      base;
      logic [HLINE-1:0] wline;
      logic [HLINE-1:0] rline;
   } op_t;

   op_t              ops[$];
   op_t              dv_q[$];
   logic [63:0]      model_mem[logic [63:0]];
   logic [63:0]      resp_mem[logic [63:0]];
   logic [HLINE-1:0] last_rline = '0;
   int               beat = 0, wcnt = 0, ack_delay = 0, dv_count = 0;
   bit               spurious = 1'b0;
   int               tests = 0, fails = 0;

   task automatic check(input string name, input logic [HLINE-1:0] act,
                        input logic [HLINE-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] fill(input logic [63:0] a);
      return a ^ 64'hC3C3_5A5A_0F0F_9696;
   endfunction

   function automatic logic [63:0] model_rd(input logic [63:0] a);
      return model_mem.exists(a) ? model_mem[a] : fill(a);
   endfunction

   function automatic logic [63:0] resp_rd(input logic [63:0] a);
      return resp_mem.exists(a) ? resp_mem[a] : fill(a);
   endfunction

   // Line-level model: beats are consecutive 8-byte words from the aligned base.
   task automatic push_op(input logic we, input logic [63:0] addr,
                          input logic [HLINE-1:0] wl);
      op_t o;
      o.we    = we;
      o.base  = addr - (addr % (HLINE / 8));
      o.wline = wl;
      o.rline = '0;
      for (int i = 0; i < BEATS; i++) begin
         if (we) model_mem[o.base + 64'(8*i)] = wl[64*i +: 64];
         else    o.rline[64*i +: 64] = model_rd(o.base + 64'(8*i));
      end
      ops.push_back(o);
   endtask

   // One cycle: compare outputs against the model, then act as the memory.
   task automatic tick();
      op_t cur;
      @(negedge clk);
      if (rst) begin
         check("rst_m_req", m_req, 0);
         check("rst_m_we", m_we, 0);
         check("rst_m_addr", m_addr, 0);
         check("rst_m_wdata", m_wdata, 0);
         check("rst_h_dv", h_dv, 0);
         check("rst_h_data_in", h_data_in, 0);
         ops.delete();
         dv_q.delete();
         beat = 0;
         wcnt = 0;
         last_rline = '0;
         m_ack = 1'b0;
         return;
      end
      if (h_dv) begin
         check("rsp_m_req", m_req, 0);
         if (dv_q.size() == 0) check("unexpected_h_dv", 1, 0);
         else begin
            cur = dv_q.pop_front();
            dv_count++;
            if (!cur.we) last_rline = cur.rline;
         end
      end
      check("h_data_in", h_data_in, last_rline);
      if (m_req) begin
         if (ops.size() == 0) check("unexpected_m_req", 1, 0);
         else begin
            cur = ops[0];
            check("m_addr", m_addr, cur.base + 64'(8*beat));
            check("m_we", m_we, cur.we);
            if (cur.we) check("m_wdata", m_wdata, cur.wline[64*beat +: 64]);
         end
      end
      m_ack   = 1'b0;
      m_rdata = {$urandom, $urandom};
      if (spurious) m_ack = 1'b1;
      else if (m_req) begin
         if (wcnt >= ack_delay) begin
            m_ack = 1'b1;
            wcnt  = 0;
            if (m_we) resp_mem[m_addr] = m_wdata;
            else      m_rdata = resp_rd(m_addr);
            if (ops.size() > 0) begin
               beat++;
               if (beat == BEATS) begin
                  dv_q.push_back(ops.pop_front());
                  beat = 0;
               end
            end
         end else wcnt++;
      end
   endtask

   task automatic wait_for_req(output int n);
      n = 0;
      do begin tick(); n++; end while (!m_req && n < 200);
      if (!m_req) check("m_req_timeout", 0, 1);
   endtask

   task automatic wait_for_dv(output int n);
      n = 0;
      do begin tick(); n++; end while (!h_dv && n < 200);
      if (!h_dv) check("h_dv_timeout", 0, 1);
   endtask

   task automatic do_op(input logic we, input logic [63:0] addr,
                        input logic [HLINE-1:0] wl, input int dly, output int total);
      int n1, n2;
      ack_delay = dly;
      push_op(we, addr, wl);
      h_addr = addr;
      h_data_out = wl;
      h_rd = !we;
      h_wr = we;
      wait_for_req(n1);
      check("first_req_latency", n1, 1);
      wait_for_dv(n2);
      h_rd = 1'b0;
      h_wr = 1'b0;
      total = n1 + n2;
   endtask

   localparam logic [HLINE-1:0] RD1_LINE =
      {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
       64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
   localparam logic [HLINE-1:0] WR1_LINE =
      {64'hCAFE_F00D_0000_0003, 64'hDEAD_BEEF_0000_0002,
       64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF};
   localparam logic [HLINE-1:0] WR2_LINE =
      {64'hA3A3_0000_1111_0003, 64'hA2A2_0000_1111_0002,
       64'hA1A1_0000_1111_0001, 64'hA0A0_0000_1111_0000};

   initial begin
      int total, n1, n2, n3;
      for (int i = 0; i < BEATS; i++) begin
         model_mem[64'h1000_0000 + 64'(8*i)] = RD1_LINE[64*i +: 64];
         resp_mem[64'h1000_0000 + 64'(8*i)]  = RD1_LINE[64*i +: 64];
      end

      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Read with immediate acks; offset bits of the address are ignored.
      do_op(1'b0, 64'h1000_0017, '0, 0, total);
      check("rd1_dv_latency", total, 5);
      check("rd1_line", h_data_in, RD1_LINE);
      repeat (2) tick();

      // Write with three wait cycles per beat; h_data_in must not move.
      do_op(1'b1, 64'h2000_0040, WR1_LINE, 3, total);
      check("wr1_dv_latency", total, 17);
      check("wr1_h_data_in_kept", h_data_in, RD1_LINE);
      repeat (2) tick();

      // Read and write together: write first, held read starts after HOLD.
      ack_delay = 1;
      push_op(1'b1, 64'h2000_0040, WR2_LINE);
      push_op(1'b0, 64'h2000_0040, '0);
      h_addr = 64'h2000_0040;
      h_data_out = WR2_LINE;
      h_rd = 1'b1;
      h_wr = 1'b1;
      wait_for_req(n1);
      check("both_first_req", m_we, 1);
      wait_for_dv(n2);
      h_wr = 1'b0;
      wait_for_req(n3);
      check("chained_read_start", n3, 3);
      check("chained_read_we", m_we, 0);
      wait_for_dv(n2);
      h_rd = 1'b0;
      check("chained_read_line", h_data_in, WR2_LINE);
      repeat (2) tick();

      // Reset during beat 2 of a read; nothing may complete afterwards.
      ack_delay = 2;
      push_op(1'b0, 64'h3000_0008, '0);
      h_addr = 64'h3000_0008;
      h_rd = 1'b1;
      n1 = 0;
      do begin tick(); n1++; end
         while (!(m_req && m_addr == 64'h3000_0010) && n1 < 200);
      check("abort_reached_beat2", m_addr, 64'h3000_0010);
      rst = 1'b1;
      h_rd = 1'b0;
      tick();
      rst = 1'b0;
      repeat (6) tick();
      do_op(1'b0, 64'h3000_0008, '0, 0, total);
      check("fresh_read_beat0", h_data_in[63:0], fill(64'h3000_0000));
      repeat (2) tick();

      // Line at the very top of the address space.
      do_op(1'b0, 64'hFFFF_FFFF_FFFF_FFE0, '0, 1, total);
      check("top_read_beat3", h_data_in[255:192], fill(64'hFFFF_FFFF_FFFF_FFF8));
      repeat (2) tick();

      // Acks with no request outstanding must be ignored.
      spurious = 1'b1;
      repeat (5) tick();
      spurious = 1'b0;
      tick();
      do_op(1'b0, 64'h1000_0000, '0, 0, total);
      check("post_spurious_latency", total, 5);
      check("post_spurious_line", h_data_in, RD1_LINE);
      repeat (3) tick();

      check("ops_drained", ops.size(), 0);
      check("dv_drained", dv_q.size(), 0);
      check("dv_count", dv_count, 7);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
